// File: rtl/score_keeper.sv
// Two-player guessing-game referee: collects one guess per player per round,
// judges them against a target, keeps saturating scores and ends the game
// once a player reaches WIN_SCORE. All outputs come straight from registers.
module score_keeper #(
  parameter int WIN_SCORE      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SHOW_CYCLES    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       p1_load,
  input  logic       p2_load,
  input  logic [3:0] p1_value,
  input  logic [3:0] p2_value,
  input  logic [3:0] target,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [1:0] round_winner,
  output logic       game_over,
  output logic       waiting
);

  localparam logic [2:0]  WIN_Q     = 3'(WIN_SCORE);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SHOW_LAST = 16'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GUESSES,
    JUDGE,
    SHOW,
    GAME_OVER
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        p1_flag_q, p2_flag_q;
  logic [3:0]  p1_val_q, p2_val_q;
  logic [2:0]  p1_score_q, p2_score_q;
  logic [1:0]  winner_q;
  logic        game_over_q, waiting_q;

  logic        p1_cap, p2_cap;
  logic        p1_flag_d, p2_flag_d;
  logic [3:0]  p1_dist, p2_dist;

  // |a - b| on 4-bit unsigned values; cannot exceed 15.
  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Score +1, pinned at WIN_SCORE so it can never wrap.
  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= WIN_Q) ? WIN_Q : (s + 3'd1);
  endfunction

  // Guess capture: only the first load of each player in a round is taken,
  // and both players can be captured in the same cycle.
  always_comb begin
    p1_cap    = (state_q == WAIT_GUESSES) && p1_load && !p1_flag_q;
    p2_cap    = (state_q == WAIT_GUESSES) && p2_load && !p2_flag_q;
    p1_flag_d = p1_flag_q | p1_cap;
    p2_flag_d = p2_flag_q | p2_cap;
    p1_dist   = abs_diff(p1_val_q, target);
    p2_dist   = abs_diff(p2_val_q, target);
  end

  // Game FSM with registered outputs; one counter serves both the guess
  // timeout in WAIT_GUESSES and the display hold in SHOW.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p1_flag_q   <= 1'b0;
      p2_flag_q   <= 1'b0;
      p1_val_q    <= '0;
      p2_val_q    <= '0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      waiting_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            state_q    <= WAIT_GUESSES;
            waiting_q  <= 1'b1;
            cnt_q      <= '0;
            p1_flag_q  <= 1'b0;
            p2_flag_q  <= 1'b0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            winner_q   <= 2'b00;
          end
        end
        WAIT_GUESSES: begin
          if (p1_cap) p1_val_q <= p1_value;
          if (p2_cap) p2_val_q <= p2_value;
          p1_flag_q <= p1_flag_d;
          p2_flag_q <= p2_flag_d;
          cnt_q     <= cnt_q + 16'd1;
          // A guess landing in the final timeout cycle is already in the _d flags.
          if ((p1_flag_d && p2_flag_d) || (cnt_q == TO_LAST)) begin
            state_q   <= JUDGE;
            waiting_q <= 1'b0;
          end
        end
        JUDGE: begin
          state_q <= SHOW;
          cnt_q   <= '0;
          if (p1_flag_q && p2_flag_q) begin
            if (p1_dist < p2_dist) begin
              winner_q   <= 2'b01;
              p1_score_q <= sat_inc(p1_score_q);
            end else if (p2_dist < p1_dist) begin
              winner_q   <= 2'b10;
              p2_score_q <= sat_inc(p2_score_q);
            end else begin
              winner_q <= 2'b11;
            end
          end else if (p1_flag_q) begin
            // Timed out with only player 1 committed: distance is irrelevant.
            winner_q   <= 2'b01;
            p1_score_q <= sat_inc(p1_score_q);
          end else if (p2_flag_q) begin
            winner_q   <= 2'b10;
            p2_score_q <= sat_inc(p2_score_q);
          end else begin
            winner_q <= 2'b00;
          end
        end
        SHOW: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == SHOW_LAST) begin
            if ((p1_score_q == WIN_Q) || (p2_score_q == WIN_Q)) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q   <= WAIT_GUESSES;
              waiting_q <= 1'b1;
              cnt_q     <= '0;
              p1_flag_q <= 1'b0;
              p2_flag_q <= 1'b0;
            end
          end
        end
        GAME_OVER: begin
          if (start_pulse) begin
            state_q     <= WAIT_GUESSES;
            game_over_q <= 1'b0;
            waiting_q   <= 1'b1;
            cnt_q       <= '0;
            p1_flag_q   <= 1'b0;
            p2_flag_q   <= 1'b0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            winner_q    <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign round_winner = winner_q;
  assign game_over    = game_over_q;
  assign waiting      = waiting_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: table of rounds driven in order, expected
// winner/scores pushed to a scoreboard queue, plus reset and game-over sequences.
module tb_score_keeper;

  localparam int WIN  = 3;
  localparam int TO   = 20;
  localparam int SHOW = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_pulse, p1_load, p2_load;
  logic [3:0] p1_value, p2_value, target;
  logic [2:0] p1_score, p2_score;
  logic [1:0] round_winner;
  logic       game_over, waiting;

  score_keeper #(.WIN_SCORE(WIN), .TIMEOUT_CYCLES(TO), .SHOW_CYCLES(SHOW)) dut (
    .clock(clock), .reset(reset), .start_pulse(start_pulse),
    .p1_load(p1_load), .p2_load(p2_load),
    .p1_value(p1_value), .p2_value(p2_value), .target(target),
    .p1_score(p1_score), .p2_score(p2_score), .round_winner(round_winner),
    .game_over(game_over), .waiting(waiting)
  );

  always #5 clock = ~clock;

  // One round: load delays are cycles after entering WAIT (-1 = no load).
  typedef struct {
    int p1_dly; int p1_val; int p1_dly2; int p1_val2;
    int p2_dly; int p2_val; int tgt;     int exp_w;
  } round_t;

  typedef struct {
    int w; int s1; int s2; int go;
  } exp_t;

  round_t tbl[7];
  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     m_s1  = 0;
  int     m_s2  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_p1_score"}, int'(p1_score), 0);
    chk({tag, "_p2_score"}, int'(p2_score), 0);
    chk({tag, "_winner"},   int'(round_winner), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_waiting"},  int'(waiting), 0);
  endtask

  // Plays one table row starting right after WAIT is entered.
  task automatic run_round(input int idx, input bit abort_in_show);
    round_t v;
    exp_t   e;
    int     maxc;
    int     n;
    bit     both;
    bit     bad;
    v    = tbl[idx];
    maxc = v.p1_dly;
    if (v.p1_dly2 > maxc) maxc = v.p1_dly2;
    if (v.p2_dly > maxc) maxc = v.p2_dly;
    both = (v.p1_dly >= 0) && (v.p2_dly >= 0);
    // Bench model of the scores, saturating at WIN.
    if (v.exp_w == 1 && m_s1 < WIN) m_s1++;
    if (v.exp_w == 2 && m_s2 < WIN) m_s2++;
    e.w = v.exp_w; e.s1 = m_s1; e.s2 = m_s2; e.go = (m_s1 == WIN || m_s2 == WIN);
    sb.push_back(e);
    target = 4'(v.tgt);
    for (int c = 0; c <= maxc; c++) begin
      p1_load  = (v.p1_dly == c) || (v.p1_dly2 == c);
      p1_value = (v.p1_dly == c) ? 4'(v.p1_val) : 4'(v.p1_val2);
      p2_load  = (v.p2_dly == c);
      p2_value = 4'(v.p2_val);
      tick();
      p1_load = 1'b0;
      p2_load = 1'b0;
    end
    if (both) chk($sformatf("r%0d_judge_latency", idx), int'(waiting), 0);
    n = 0;
    while (waiting && n < TO + 5) begin
      tick();
      n++;
    end
    chk($sformatf("r%0d_left_wait", idx), int'(waiting), 0);
    if (!both) chk($sformatf("r%0d_timeout_len", idx), maxc + 1 + n, TO);
    tick();
    e = sb.pop_front();
    chk($sformatf("r%0d_winner", idx), int'(round_winner), e.w);
    chk($sformatf("r%0d_p1_score", idx), int'(p1_score), e.s1);
    chk($sformatf("r%0d_p2_score", idx), int'(p2_score), e.s2);
    if (abort_in_show) return;
    // start/load pulses during SHOW must not shorten it.
    start_pulse = 1'b1;
    p1_load     = 1'b1;
    tick();
    start_pulse = 1'b0;
    p1_load     = 1'b0;
    bad = waiting;
    for (int k = 0; k < SHOW - 2; k++) begin
      tick();
      if (waiting || game_over) bad = 1'b1;
    end
    chk($sformatf("r%0d_show_hold", idx), int'(bad), 0);
    tick();
    chk($sformatf("r%0d_after_show_wait", idx), int'(waiting), e.go ? 0 : 1);
    chk($sformatf("r%0d_after_show_go", idx), int'(game_over), e.go);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           p1d p1v p1d2 p1v2 p2d p2v tgt w
    tbl[0] = '{ 0,  6, -1, 0,  2, 10,  7, 1};  // p1 closer
    tbl[1] = '{ 0,  3, -1, 0,  0,  7,  5, 3};  // same cycle, tie
    tbl[2] = '{-1,  0, -1, 0,  0,  0, 15, 2};  // p2 alone, timeout
    tbl[3] = '{-1,  0, -1, 0, -1,  0,  9, 0};  // nobody, timeout
    tbl[4] = '{ 0, 15, -1, 0,  1, 14,  0, 2};  // p2 closer
    tbl[5] = '{ 0,  2,  1, 9,  3,  8,  3, 1};  // second p1 load ignored
    tbl[6] = '{TO-1, 1, -1, 0, -1, 0, 0, 1};   // p1 in final timeout cycle

    reset = 1'b0; start_pulse = 1'b0; p1_load = 1'b0; p2_load = 1'b0;
    p1_value = '0; p2_value = '0; target = '0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();
    tick();
    chk("idle_holds", int'(waiting), 0);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("start_waiting", int'(waiting), 1);

    for (int i = 0; i < 7; i++) run_round(i, 1'b0);

    // Game over: held against loads, cleared by start.
    p1_load = 1'b1; p2_load = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    p1_load = 1'b0; p2_load = 1'b0;
    chk("go_flag", int'(game_over), 1);
    chk("go_p1_held", int'(p1_score), 3);
    chk("go_p2_held", int'(p2_score), 2);
    chk("go_winner_held", int'(round_winner), 1);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("restart_p1", int'(p1_score), 0);
    chk("restart_p2", int'(p2_score), 0);
    chk("restart_winner", int'(round_winner), 0);
    chk("restart_go", int'(game_over), 0);
    chk("restart_waiting", int'(waiting), 1);
    m_s1 = 0; m_s2 = 0;

    // Reset mid-WAIT with only p1 committed.
    p1_load = 1'b1; p1_value = 4'd5;
    tick();
    p1_load = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("rst_wait");
    start_pulse = 1'b1;
    tick();
    tick();
    start_pulse = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_wait_idle", int'(waiting), 0);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("rst_restart_waiting", int'(waiting), 1);
    m_s1 = 0; m_s2 = 0;
    run_round(2, 1'b0);  // stale p1 flag would make p1 win here

    // Reset mid-SHOW with a nonzero score.
    run_round(0, 1'b1);
    tick();
    #2 reset = 1'b0;
    #1 chk_zero("rst_show");
    tick();
    reset = 1'b1;
    tick();
    chk("rst_show_idle", int'(waiting), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
